// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC -> MAR -> memory read -> MDR -> IR, with decode handshake.
// Optional memory-wait timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h3000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        MEM_REQ,
    output logic [15:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [15:0] MEM_RDATA,
    output logic [15:0] INSTRUCTION,
    output logic        IR_VALID,
    input  logic        IR_READY,
    input  logic        PC_LD,
    input  logic [15:0] PC_IN,
    output logic [15:0] PC,
    output logic        MAR_LE,
    output logic        MDR_LE,
    output logic        PC_LE,
    output logic        IR_LE,
    output logic        FETCH_ERR
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef FETCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    // Timeout path is folded away: counter never advances, S_ERR is never entered.
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_ADDR = 3'd0,
        S_REQ  = 3'd1,
        S_LOAD = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_pc;
    logic [15:0]        r_mar;
    logic [15:0]        r_mdr;
    logic [15:0]        r_ir;
    logic               r_mem_req;
    logic               r_ir_valid;
    logic               r_mar_le;
    logic               r_mdr_le;
    logic               r_pc_le;
    logic               r_ir_le;
    logic               r_err;
    logic               r_redir;
    logic [TMO_W-1:0]   r_tmo_cnt;

    logic               w_mar_ld;
    logic               w_mdr_ld;
    logic               w_pc_inc;
    logic               w_pc_redir;
    logic               w_ir_ld;
    logic               w_err_set;
    logic               w_err_clr;
    logic               w_tmo_hit;

    assign w_tmo_hit = TMO_EN && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Next-state and register-load decode.
    always_comb begin
        w_next     = r_state;
        w_mar_ld   = 1'b0;
        w_mdr_ld   = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_redir = 1'b0;
        w_ir_ld    = 1'b0;
        w_err_set  = 1'b0;
        w_err_clr  = 1'b0;
        case (r_state)
            S_ADDR: begin
                if (PC_LD) begin
                    w_pc_redir = 1'b1;
                    w_next     = S_ADDR;
                end else begin
                    w_mar_ld = 1'b1;
                    w_next   = S_REQ;
                end
            end
            S_REQ: begin
                // A redirect never aborts the bus read; it only discards the data.
                if (PC_LD) begin
                    w_pc_redir = 1'b1;
                end
                if (MEM_ACK) begin
                    if (PC_LD || r_redir) begin
                        w_next = S_ADDR;
                    end else begin
                        w_mdr_ld = 1'b1;
                        w_pc_inc = 1'b1;
                        w_next   = S_LOAD;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set = 1'b1;
                    w_next    = S_ERR;
                end
            end
            S_LOAD: begin
                if (PC_LD) begin
                    w_pc_redir = 1'b1;
                    w_next     = S_ADDR;
                end else begin
                    w_ir_ld = 1'b1;
                    w_next  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (PC_LD) begin
                    w_pc_redir = 1'b1;
                    w_next     = S_ADDR;
                end else if (IR_READY) begin
                    w_next = S_ADDR;
                end
            end
            S_ERR: begin
                if (PC_LD) begin
                    w_pc_redir = 1'b1;
                    w_err_clr  = 1'b1;
                    w_next     = S_ADDR;
                end
            end
            default: w_next = S_ADDR;
        endcase
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= S_ADDR;
            r_pc       <= RESET_PC;
            r_mar      <= 16'h0000;
            r_mdr      <= 16'h0000;
            r_ir       <= 16'h0000;
            r_mem_req  <= 1'b0;
            r_ir_valid <= 1'b0;
            r_mar_le   <= 1'b0;
            r_mdr_le   <= 1'b0;
            r_pc_le    <= 1'b0;
            r_ir_le    <= 1'b0;
            r_err      <= 1'b0;
            r_redir    <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_mar_ld) begin
                r_mar <= r_pc;
            end
            if (w_mdr_ld) begin
                r_mdr <= MEM_RDATA;
            end
            if (w_pc_redir) begin
                r_pc <= PC_IN;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + 16'd1;
            end
            if (w_ir_ld) begin
                r_ir <= r_mdr;
            end
            r_mem_req  <= (w_next == S_REQ);
            r_ir_valid <= (w_next == S_HOLD);
            r_mar_le   <= w_mar_ld;
            r_mdr_le   <= w_mdr_ld;
            r_pc_le    <= w_pc_inc | w_pc_redir;
            r_ir_le    <= w_ir_ld;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            // Remember a redirect seen while the read is still outstanding.
            r_redir <= (w_next == S_REQ) && (r_redir || ((r_state == S_REQ) && PC_LD));
            if (TMO_EN && (r_state == S_REQ) && !MEM_ACK && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign MEM_REQ     = r_mem_req;
    assign MEM_ADDR    = r_mar;
    assign INSTRUCTION = r_ir;
    assign IR_VALID    = r_ir_valid;
    assign PC          = r_pc;
    assign MAR_LE      = r_mar_le;
    assign MDR_LE      = r_mdr_le;
    assign PC_LE       = r_pc_le;
    assign IR_LE       = r_ir_le;
    assign FETCH_ERR   = r_err;

endmodule
